// File: rtl/uart_wishbone_bridge_if.sv
// Wishbone bus bundle between the UART bridge (master) and the SoC interconnect (slave).
interface uart_wishbone_bridge_if;
  logic [29:0] wb_adr;
  logic [31:0] wb_dat_w;
  logic [31:0] wb_dat_r;
  logic [3:0]  wb_sel;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic        wb_ack;

  modport master (output wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we,
                  input  wb_dat_r, wb_ack);
  modport slave  (input  wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we,
                  output wb_dat_r, wb_ack);
endinterface

// File: rtl/uart_wishbone_bridge.sv
// UART command-packet receiver driving a single-word Wishbone master; read data goes back out on uart_tx.
module uart_wishbone_bridge #(
  parameter int CLK_DIV = 217,
  parameter int TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic uart_rx,
  output logic uart_tx,
  output logic busy,
  uart_wishbone_bridge_if.master wb
);
  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  localparam logic [1:0] RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3;
  localparam logic [2:0] S_IDLE = 3'd0, S_LEN = 3'd1, S_ADDR = 3'd2, S_WDATA = 3'd3,
                         S_WB_WRITE = 3'd4, S_WB_READ = 3'd5, S_TXDATA = 3'd6;

  logic          rx_s1_q, rx_s2_q, rx_valid_q, rx_ferr_q;
  logic [1:0]    rx_st_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_sh_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_st_q <= RX_IDLE; rx_cnt_q <= '0;
      rx_bit_q <= '0; rx_sh_q <= '0; rx_valid_q <= 1'b0; rx_ferr_q <= 1'b0;
    end else begin
      rx_s1_q <= uart_rx;
      rx_s2_q <= rx_s1_q;
      rx_valid_q <= 1'b0;
      rx_ferr_q <= 1'b0;
      rx_cnt_q <= rx_cnt_q + CW'(1);
      case (rx_st_q)
        RX_IDLE: begin
          rx_cnt_q <= '0;
          if (!rx_s2_q) rx_st_q <= RX_START;
        end
        // Mid-start re-check rejects glitches shorter than half a bit.
        RX_START: if (rx_cnt_q == HALF) begin
          rx_cnt_q <= '0;
          rx_bit_q <= '0;
          rx_st_q  <= rx_s2_q ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (rx_cnt_q == FULL) begin
          rx_cnt_q <= '0;
          rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_q <= rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_st_q <= RX_STOP;
        end
        default: if (rx_cnt_q == FULL) begin
          rx_cnt_q   <= '0;
          rx_valid_q <= rx_s2_q;
          rx_ferr_q  <= !rx_s2_q;
          rx_st_q    <= RX_IDLE;
        end
      endcase
    end
  end

  logic          tx_start, tx_done, tx_act_q;
  logic [7:0]    tx_byte;
  logic [9:0]    tx_sh_q;
  logic [3:0]    tx_bit_q;
  logic [CW-1:0] tx_cnt_q;

  // A new byte may be loaded in the last stop-bit cycle, so back-to-back bytes have no gap.
  assign tx_done = tx_act_q && (tx_bit_q == 4'd9) && (tx_cnt_q == FULL);
  assign uart_tx = tx_sh_q[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_sh_q <= '1; tx_bit_q <= '0; tx_cnt_q <= '0; tx_act_q <= 1'b0;
    end else if (tx_start) begin
      tx_sh_q <= {1'b1, tx_byte, 1'b0}; tx_bit_q <= '0; tx_cnt_q <= '0; tx_act_q <= 1'b1;
    end else if (tx_act_q) begin
      if (tx_cnt_q == FULL) begin
        tx_cnt_q <= '0;
        tx_bit_q <= tx_bit_q + 4'd1;
        tx_sh_q  <= {1'b1, tx_sh_q[9:1]};
        if (tx_bit_q == 4'd9) tx_act_q <= 1'b0;
      end else begin
        tx_cnt_q <= tx_cnt_q + CW'(1);
      end
    end
  end

  logic [2:0]    st_q, st_d;
  logic          rd_q, rd_d, stb_q, stb_d, we_q, we_d;
  logic [7:0]    len_q, len_d, wcnt_q, wcnt_d;
  logic [1:0]    bidx_q, bidx_d;
  logic [23:0]   sh_q, sh_d;
  logic [31:0]   rdat_q, rdat_d, dat_w_q, dat_w_d;
  logic [29:0]   adr_q, adr_d;
  logic [TW-1:0] to_q, to_d;

  always_comb begin
    st_d = st_q; rd_d = rd_q; len_d = len_q; wcnt_d = wcnt_q; bidx_d = bidx_q;
    sh_d = sh_q; rdat_d = rdat_q; adr_d = adr_q; dat_w_d = dat_w_q;
    stb_d = stb_q; we_d = we_q; to_d = '0;
    tx_start = 1'b0;
    tx_byte  = rdat_q[31:24];
    case (st_q)
      S_IDLE: if (rx_valid_q && (rx_sh_q == 8'h01 || rx_sh_q == 8'h02)) begin
        st_d = S_LEN;
        rd_d = rx_sh_q[1];
      end
      S_LEN: if (rx_valid_q) begin
        len_d = rx_sh_q; bidx_d = 2'd0; st_d = S_ADDR;
      end
      S_ADDR, S_WDATA: if (rx_valid_q) begin
        sh_d   = {sh_q[15:0], rx_sh_q};
        bidx_d = bidx_q + 2'd1;
        if (bidx_q == 2'd3) begin
          if (st_q == S_ADDR) begin
            adr_d  = {sh_q[21:0], rx_sh_q};
            wcnt_d = '0;
            if (len_q == 8'd0) st_d = S_IDLE;
            else if (rd_q) begin st_d = S_WB_READ; stb_d = 1'b1; end
            else st_d = S_WDATA;
          end else begin
            dat_w_d = {sh_q, rx_sh_q}; stb_d = 1'b1; we_d = 1'b1; st_d = S_WB_WRITE;
          end
        end
      end
      S_WB_WRITE: if (wb.wb_ack) begin
        stb_d = 1'b0; we_d = 1'b0;
        adr_d = adr_q + 30'd1; wcnt_d = wcnt_q + 8'd1;
        st_d  = (wcnt_q + 8'd1 == len_q) ? S_IDLE : S_WDATA;
      end
      S_WB_READ: if (wb.wb_ack) begin
        stb_d = 1'b0; adr_d = adr_q + 30'd1; wcnt_d = wcnt_q + 8'd1;
        rdat_d = {wb.wb_dat_r[23:0], 8'h00};
        tx_start = 1'b1; tx_byte = wb.wb_dat_r[31:24];
        bidx_d = 2'd1; st_d = S_TXDATA;
      end
      // bidx counts bytes already started; wrapping to 0 means all four have gone out.
      S_TXDATA: if (tx_done) begin
        if (bidx_q != 2'd0) begin
          tx_start = 1'b1; rdat_d = {rdat_q[23:0], 8'h00}; bidx_d = bidx_q + 2'd1;
        end else if (wcnt_q == len_q) st_d = S_IDLE;
        else begin st_d = S_WB_READ; stb_d = 1'b1; end
      end
      default: st_d = S_IDLE;
    endcase
    if (st_q == S_LEN || st_q == S_ADDR || st_q == S_WDATA) begin
      if (!rx_valid_q) to_d = to_q + TW'(1);
      if (!rx_valid_q && (rx_ferr_q || to_q == TMAX)) st_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q <= S_IDLE; rd_q <= 1'b0; len_q <= '0; wcnt_q <= '0; bidx_q <= '0;
      sh_q <= '0; rdat_q <= '0; adr_q <= '0; dat_w_q <= '0;
      stb_q <= 1'b0; we_q <= 1'b0; to_q <= '0;
    end else begin
      st_q <= st_d; rd_q <= rd_d; len_q <= len_d; wcnt_q <= wcnt_d; bidx_q <= bidx_d;
      sh_q <= sh_d; rdat_q <= rdat_d; adr_q <= adr_d; dat_w_q <= dat_w_d;
      stb_q <= stb_d; we_q <= we_d; to_q <= to_d;
    end
  end

  assign busy        = (st_q != S_IDLE);
  assign wb.wb_cyc   = stb_q;
  assign wb.wb_stb   = stb_q;
  assign wb.wb_we    = we_q;
  assign wb.wb_sel   = {4{stb_q}};
  assign wb.wb_adr   = adr_q;
  assign wb.wb_dat_w = dat_w_q;
endmodule
